adc_emul_seq: RTL and testbench

Burst sequencer and pattern controller for the ADC emulator datapath. Accepts a configuration word in idle, then on `start` drives a programmable number of sample bursts, each of fixed length and separated by a fixed idle gap. Produces one WIDTH-bit sample per clock during bursts from a selectable pattern. Sits between the test/control logic and the DDR LVDS serializer, which consumes `sample` and `sample_valid`.

---
 rtl/adc_emul_pkg.sv | 25 ++
 rtl/adc_emul_seq_if.sv | 41 ++++
 rtl/adc_emul_pattern.sv | 91 +++++++++
 rtl/adc_emul_seq.sv | 143 ++++++++++++++
 tb/tb_adc_emul_seq.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_emul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_emul_pkg                                                         |
// | Shared constants and FSM state type for the ADC emulator sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_emul_pkg;

    localparam int C_DEF_WIDTH = 4;
    localparam int C_DEF_CNT_W = 16;

    localparam logic [1:0] C_MODE_TRI   = 2'd0;
    localparam logic [1:0] C_MODE_RAMP  = 2'd1;
    localparam logic [1:0] C_MODE_CONST = 2'd2;
    localparam logic [1:0] C_MODE_CHK   = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE = 2'd0;
    localparam state_t C_ST_RUN  = 2'd1;
    localparam state_t C_ST_GAP  = 2'd2;
    localparam state_t C_ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/adc_emul_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_emul_seq_if                                                      |
// | Config, control and sample bus between controller and sequencer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface adc_emul_seq_if
    import adc_emul_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int CNT_W = C_DEF_CNT_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_step;
    logic [CNT_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_gap;
    logic [7:0]       cfg_bursts;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             frame_start;

    modport master (
        output cfg_valid, cfg_mode, cfg_step, cfg_len, cfg_gap, cfg_bursts,
        output start, abort,
        input  cfg_ready, busy, done, aborted, sample, sample_valid, frame_start
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_step, cfg_len, cfg_gap, cfg_bursts,
        input  start, abort,
        output cfg_ready, busy, done, aborted, sample, sample_valid, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/adc_emul_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_emul_pattern                                                     |
// | Triangle / ramp / constant / checkerboard sample generator.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_emul_pattern
    import adc_emul_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_step,
    output logic [WIDTH-1:0] o_sample
);
    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_val;
    logic             r_dir_down;
    logic             r_phase;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_val_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_chk;

    assign w_step = (i_step == '0) ? C_ONE : i_step;

    // The direction flips on the sample that reaches an end, so neither MAX nor 0 repeats.
    always_comb begin
        w_val_nxt = r_val;
        w_dir_nxt = r_dir_down;
        case (i_mode)
            C_MODE_TRI: begin
                if (!r_dir_down) begin
                    if (r_val >= C_MAX - w_step) begin
                        w_val_nxt = C_MAX;
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_val_nxt = r_val + w_step;
                    end
                end else begin
                    if (r_val <= w_step) begin
                        w_val_nxt = '0;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_val_nxt = r_val - w_step;
                    end
                end
            end
            C_MODE_RAMP: w_val_nxt = r_val + w_step;
            default:     w_val_nxt = r_val;
        endcase
    end

    always_comb begin
        w_chk = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_chk[i] = (i % 2 == 0) ^ r_phase;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_val      <= '0;
            r_dir_down <= 1'b0;
            r_phase    <= 1'b0;
        end else if (i_clr) begin
            r_val      <= '0;
            r_dir_down <= 1'b0;
            r_phase    <= 1'b0;
        end else if (i_adv) begin
            r_val      <= w_val_nxt;
            r_dir_down <= w_dir_nxt;
            r_phase    <= ~r_phase;
        end
    end

    always_comb begin
        case (i_mode)
            C_MODE_CONST: o_sample = i_step;
            C_MODE_CHK:   o_sample = w_chk;
            default:      o_sample = r_val;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/adc_emul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_emul_seq                                                         |
// | Burst sequencer: config capture, burst/gap FSM, pattern sample out.  |
// | Optional frame marker: define ADC_EMUL_SEQ_FRAME_EN.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_emul_seq
    import adc_emul_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int CNT_W = C_DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    adc_emul_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       C_BURST_ONE = 8'd1;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_step;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_gap;
    logic [7:0]       r_bursts;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [7:0]       r_burst_cnt;
    logic             r_aborted;

    logic             w_accept;
    logic             w_cap;
    logic             w_go;
    logic [CNT_W-1:0] w_len;
    logic [7:0]       w_bursts;
    logic             w_run;
    logic             w_last_sample;
    logic             w_last_burst;
    logic             w_gap_end;
    logic [WIDTH-1:0] w_pat;

    // The cycle carrying the aborted pulse is a recovery cycle: no config or start accepted.
    assign w_accept      = (r_state == C_ST_IDLE) && !r_aborted;
    assign w_cap         = w_accept && bus.cfg_valid;
    assign w_go          = w_accept && bus.start;
    assign w_len         = w_cap ? bus.cfg_len    : r_len;
    assign w_bursts      = w_cap ? bus.cfg_bursts : r_bursts;
    assign w_run         = (r_state == C_ST_RUN);
    assign w_last_sample = (r_cnt == r_len - C_CNT_ONE);
    assign w_last_burst  = (r_burst_cnt == r_bursts - C_BURST_ONE);
    assign w_gap_end     = (r_gap_cnt == r_gap - C_CNT_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= C_ST_IDLE;
            r_mode      <= '0;
            r_step      <= '0;
            r_len       <= '0;
            r_gap       <= '0;
            r_bursts    <= '0;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_burst_cnt <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if (w_cap) begin
                r_mode   <= bus.cfg_mode;
                r_step   <= bus.cfg_step;
                r_len    <= bus.cfg_len;
                r_gap    <= bus.cfg_gap;
                r_bursts <= bus.cfg_bursts;
            end
            if (bus.abort && (r_state != C_ST_IDLE)) begin
                r_state   <= C_ST_IDLE;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    C_ST_IDLE: begin
                        if (w_go) begin
                            r_cnt       <= '0;
                            r_gap_cnt   <= '0;
                            r_burst_cnt <= '0;
                            r_state     <= ((w_len != '0) && (w_bursts != '0)) ? C_ST_RUN : C_ST_DONE;
                        end
                    end
                    C_ST_RUN: begin
                        if (w_last_sample) begin
                            r_cnt <= '0;
                            if (w_last_burst) begin
                                r_state <= C_ST_DONE;
                            end else begin
                                r_burst_cnt <= r_burst_cnt + C_BURST_ONE;
                                if (r_gap != '0) begin
                                    r_gap_cnt <= '0;
                                    r_state   <= C_ST_GAP;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end
                    C_ST_GAP: begin
                        if (w_gap_end) begin
                            r_state <= C_ST_RUN;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + C_CNT_ONE;
                        end
                    end
                    C_ST_DONE: r_state <= C_ST_IDLE;
                    default:   r_state <= C_ST_IDLE;
                endcase
            end
        end
    end

    adc_emul_pattern #(
        .WIDTH (WIDTH)
    ) u_pattern (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_go),
        .i_adv    (w_run),
        .i_mode   (r_mode),
        .i_step   (r_step),
        .o_sample (w_pat)
    );

    assign bus.cfg_ready    = w_accept;
    assign bus.busy         = (r_state != C_ST_IDLE);
    assign bus.done         = (r_state == C_ST_DONE);
    assign bus.aborted      = r_aborted;
    assign bus.sample_valid = w_run;
    assign bus.sample       = w_run ? w_pat : '0;

`ifdef ADC_EMUL_SEQ_FRAME_EN
    assign bus.frame_start = w_run && (r_cnt == '0);
`else
    assign bus.frame_start = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_adc_emul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_emul_seq                                                      |
// | Directed self-checking bench for adc_emul_seq.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adc_emul_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adc_emul_seq_if #(.WIDTH(4), .CNT_W(16)) bus ();

    adc_emul_seq #(.WIDTH(4), .CNT_W(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef ADC_EMUL_SEQ_FRAME_EN
    localparam bit C_FRAME = 1'b1;
`else
    localparam bit C_FRAME = 1'b0;
`endif

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [1:0] mode, input logic [3:0] step,
                             input logic [15:0] len, input logic [15:0] gap,
                             input logic [7:0] bursts);
        bus.cfg_mode = mode; bus.cfg_step = step; bus.cfg_len = len;
        bus.cfg_gap = gap; bus.cfg_bursts = bursts; bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    // Returns at the negedge of the first cycle after start is sampled (k = 1).
    task automatic do_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", bus.cfg_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0 || bus.aborted !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b aborted=%b want 0/0", bus.done, bus.aborted); end
        checks++; if (bus.sample !== 4'h0 || bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample got %h/%b want 0/0", bus.sample, bus.sample_valid); end
        checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", bus.frame_start); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_triangle;
        logic [3:0] exp;
        write_cfg(2'd0, 4'd1, 16'd32, 16'd0, 8'd1);
        do_start();
        for (int k = 1; k <= 34; k++) begin
            if (k <= 32) begin
                exp = (k - 1 < 16) ? 4'(k - 1) : ((k - 1 < 31) ? 4'(30 - (k - 1)) : 4'(k - 31));
                checks++; if (bus.sample_valid !== 1'b1 || bus.sample !== exp) begin errors++; $display("FAIL tri_sample k=%0d got %h/%b want %h/1", k, bus.sample, bus.sample_valid, exp); end
                checks++; if (bus.frame_start !== (C_FRAME && k == 1)) begin errors++; $display("FAIL tri_frame k=%0d got %b", k, bus.frame_start); end
            end
            checks++; if (bus.done !== (k == 33)) begin errors++; $display("FAIL tri_done k=%0d got %b want %b", k, bus.done, k == 33); end
            if (k == 33) begin
                checks++; if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL tri_done_cycle got valid=%b busy=%b want 0/1", bus.sample_valid, bus.busy); end
            end
            if (k == 34) begin
                checks++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL tri_idle got busy=%b ready=%b want 0/1", bus.busy, bus.cfg_ready); end
            end
            tick();
        end
    endtask

    task automatic test_ramp_gap;
        int         idx, b, j, frames;
        logic       inb;
        logic [3:0] exp;
        frames = 0;
        write_cfg(2'd1, 4'd3, 16'd8, 16'd2, 8'd3);
        do_start();
        for (int k = 1; k <= 30; k++) begin
            idx = k - 1; b = idx / 10; j = idx % 10;
            inb = (b < 3) && (j < 8);
            exp = inb ? 4'((3 * (8 * b + j)) % 16) : 4'h0;
            checks++; if (bus.sample_valid !== inb || bus.sample !== exp) begin errors++; $display("FAIL ramp_sample k=%0d got %h/%b want %h/%b", k, bus.sample, bus.sample_valid, exp, inb); end
            checks++; if (bus.done !== (k == 29)) begin errors++; $display("FAIL ramp_done k=%0d got %b want %b", k, bus.done, k == 29); end
            if (bus.frame_start === 1'b1) frames++;
            tick();
        end
        checks++; if (frames != (C_FRAME ? 3 : 0)) begin errors++; $display("FAIL ramp_frames got %0d want %0d", frames, C_FRAME ? 3 : 0); end
    endtask

    task automatic test_zero_len;
        write_cfg(2'd2, 4'hA, 16'd0, 16'd0, 8'd1);
        do_start();
        checks++; if (bus.done !== 1'b1 || bus.sample_valid !== 1'b0) begin errors++; $display("FAIL zlen_done got done=%b valid=%b want 1/0", bus.done, bus.sample_valid); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sample_valid !== 1'b0) begin errors++; $display("FAIL zlen_after got done=%b busy=%b valid=%b want 0/0/0", bus.done, bus.busy, bus.sample_valid); end
        write_cfg(2'd2, 4'hA, 16'd4, 16'd0, 8'd1);
        do_start();
        for (int k = 1; k <= 5; k++) begin
            checks++; if (bus.sample_valid !== (k <= 4) || bus.sample !== ((k <= 4) ? 4'hA : 4'h0)) begin errors++; $display("FAIL const_sample k=%0d got %h/%b", k, bus.sample, bus.sample_valid); end
            tick();
        end
    endtask

    task automatic test_abort;
        int ab_cnt, dn_cnt;
        logic [3:0] exp;
        ab_cnt = 0; dn_cnt = 0;
        write_cfg(2'd3, 4'd0, 16'd100, 16'd0, 8'd2);
        do_start();
        for (int k = 1; k <= 50; k++) begin
            exp = ((k - 1) % 2 == 0) ? 4'h5 : 4'hA;
            checks++; if (bus.sample_valid !== 1'b1 || bus.sample !== exp) begin errors++; $display("FAIL chk_sample k=%0d got %h/%b want %h/1", k, bus.sample, bus.sample_valid, exp); end
            if (k < 50) tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++; if (bus.sample_valid !== 1'b0 || bus.aborted !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_t1 got valid=%b aborted=%b done=%b want 0/1/0", bus.sample_valid, bus.aborted, bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        for (int k = 51; k <= 60; k++) begin
            if (bus.aborted === 1'b1) ab_cnt++;
            if (bus.done === 1'b1) dn_cnt++;
            if (k == 52) begin
                checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", bus.cfg_ready); end
            end
            tick();
        end
        checks++; if (ab_cnt != 1 || dn_cnt != 0) begin errors++; $display("FAIL abort_pulses got aborted=%0d done=%0d want 1/0", ab_cnt, dn_cnt); end
    endtask

    task automatic test_cfg_busy;
        write_cfg(2'd1, 4'd1, 16'd10, 16'd0, 8'd1);
        do_start();
        tick(); tick();
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", bus.cfg_ready); end
        write_cfg(2'd0, 4'd5, 16'd0, 16'd0, 8'd0);
        for (int k = 5; k <= 12; k++) tick();
        do_start();
        for (int k = 1; k <= 11; k++) begin
            checks++; if (bus.sample_valid !== (k <= 10) || bus.sample !== ((k <= 10) ? 4'(k - 1) : 4'h0)) begin errors++; $display("FAIL keep_cfg k=%0d got %h/%b", k, bus.sample, bus.sample_valid); end
            checks++; if (bus.done !== (k == 11)) begin errors++; $display("FAIL keep_done k=%0d got %b want %b", k, bus.done, k == 11); end
            tick();
        end
        bus.cfg_mode = 2'd3; bus.cfg_step = 4'd0; bus.cfg_len = 16'd4;
        bus.cfg_gap = 16'd0; bus.cfg_bursts = 8'd1; bus.cfg_valid = 1'b1;
        do_start();
        bus.cfg_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (bus.sample_valid !== (k <= 4) || bus.sample !== ((k <= 4) ? (k % 2 == 1 ? 4'h5 : 4'hA) : 4'h0)) begin errors++; $display("FAIL cfg_start k=%0d got %h/%b", k, bus.sample, bus.sample_valid); end
            checks++; if (bus.done !== (k == 5)) begin errors++; $display("FAIL cfg_start_done k=%0d got %b", k, bus.done); end
            tick();
        end
    endtask

    task automatic test_reset_gap;
        int pulses;
        pulses = 0;
        write_cfg(2'd1, 4'd1, 16'd4, 16'd3, 8'd2);
        do_start();
        for (int k = 1; k < 5; k++) tick();
        checks++; if (bus.busy !== 1'b1 || bus.sample_valid !== 1'b0) begin errors++; $display("FAIL gap_state got busy=%b valid=%b want 1/0", bus.busy, bus.sample_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.sample !== 4'h0 || bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_gap got busy=%b ready=%b sample=%h valid=%b", bus.busy, bus.cfg_ready, bus.sample, bus.sample_valid); end
        checks++; if (bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.frame_start !== 1'b0) begin errors++; $display("FAIL rst_gap_pulses got done=%b aborted=%b frame=%b", bus.done, bus.aborted, bus.frame_start); end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.done === 1'b1 || bus.aborted === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_no_pulse got %0d want 0", pulses); end
        do_start();
        checks++; if (bus.done !== 1'b1 || bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_zero_cfg got done=%b valid=%b want 1/0", bus.done, bus.sample_valid); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_zero_idle got %b want 0", bus.busy); end
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_step = 4'd0;
        bus.cfg_len = 16'd0; bus.cfg_gap = 16'd0; bus.cfg_bursts = 8'd0;
        bus.start = 1'b0; bus.abort = 1'b0;
        #2;
        test_reset();
        test_triangle();
        test_ramp_gap();
        test_zero_len();
        test_abort();
        test_cfg_busy();
        test_reset_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
